spike_rate_decoder: RTL
=======================

# spike_rate_decoder

Receive-side companion to the leaky integrate-and-fire neuron. It takes the neuron's one-bit spike output and decodes it back into numbers:
- spikes counted per programmable window (rate);
- cycles between consecutive spikes (inter-spike interval, ISI).

It sits downstream of the neuron core on the TinyTapeout tile and drives the readout pins.

## Interface

Parameters:
- CNT_W, default 8: width of the rate and ISI results; both saturate at 2^CNT_W-1.
- WIN_W, default 8: width of the window-length input.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  count enable; low freezes the window counter, spike counter and ISI counter.
- clear  input  1  synchronous clear; same effect as reset, sampled on clk.
- spike_in  input  1  spike level from the neuron, synchronous to clk.
- win_len  input  WIN_W  window length in cycles; 0 means 2^WIN_W.
- rate_out  output  CNT_W  spike count of the last completed window.
- rate_valid  output  1  one-cycle pulse when rate_out updates.
- isi_out  output  CNT_W  last measured inter-spike interval, in cycles.
- isi_valid  output  1  one-cycle pulse when isi_out updates.
- isi_sat  output  1  high when the last isi_out saturated.

## Operation

- Edge detect: spike_prev <= spike_in every cycle, regardless of ena. edge = spike_in & ~spike_prev. Only rising edges count, so a level held N cycles is one spike.
- Window:
  - win_len is latched into win_len_q at reset/clear release and at each window start.
  - win_cnt runs 0..N-1, where N = win_len_q, or 2^WIN_W if win_len_q is 0.
  - spike_cnt increments on edge, saturating at 2^CNT_W-1.
  - On the final cycle (win_cnt == N-1, ena high): rate_out <= sat(spike_cnt + edge); rate_valid pulses; spike_cnt <= 0; win_cnt <= 0; win_len relatched.
- ISI FSM, two states:
  - NO_REF: no reference spike yet. On edge, go to TIMING with isi_cnt <= 1. No isi_valid.
  - TIMING: isi_cnt increments each enabled cycle, saturating at 2^CNT_W-1. On edge: isi_out <= isi_cnt; isi_sat <= (isi_cnt == max); isi_valid pulses; isi_cnt <= 1; stay in TIMING.
- Result: edges k cycles apart give isi_out = k. Every edge after the first yields one isi_valid.
- ena low: win_cnt, spike_cnt, isi_cnt and the FSM hold; spike_prev still updates. An edge while ena is low is dropped, not deferred.
- clear has priority over ena and edges.
- Reset/clear values: every output 0, FSM = NO_REF, all counters 0, spike_prev = 0.
- Consequence of spike_prev = 0: spike_in high in the first cycle after reset counts as an edge.

## Timing

- All outputs are registered. rate_valid and isi_valid are high for exactly one cycle, in the cycle after the causing clock edge.
- rate_out and isi_out hold their value until the next update.
- Window latency: the result appears 1 cycle after the final window cycle. The window period is exactly N enabled cycles, with no dead cycle between windows.
- An edge on the final window cycle counts in the closing window; the new window starts at 0.
- An edge coinciding with a window close updates rate and ISI in the same cycle. Both valid pulses may coincide.
- Saturated spike_cnt stays at max until the window closes; rate_out then reads max.
- A win_len change mid-window takes effect at the next window start only.
- Reset asserted mid-window: the partial count is discarded and no rate_valid is issued.

## Test plan

- win_len=10, spike_in toggling 1/0 every cycle, ena=1 -> rate_valid every 10 cycles with rate_out=5; first pulse 11 cycles after reset release.
- Spike edges at cycles 3, 10, 30 -> no isi_valid at 3; isi_out=7 after cycle 10; isi_out=20 after cycle 30; isi_sat=0.
- Edges 400 cycles apart, CNT_W=8 -> isi_out=255, isi_sat=1; the following edge pair 5 apart -> isi_out=5, isi_sat=0.
- spike_in held high for 50 cycles, win_len=0 -> one edge counted; rate_out=1 after 256 cycles.
- win_len=8, ena low for 4 cycles mid-window with an edge inside that gap -> window stretches to 12 wall cycles; the gap edge is not counted.
- rst_n pulsed low asynchronously mid-window and mid-ISI -> all outputs 0 immediately; no valid pulses; the next edge re-arms ISI from NO_REF.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - decodes a spike train into per-window rate and inter-spike interval
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [CNT_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             isi_sat
);

    typedef enum logic {
        NO_REF = 1'b0,
        TIMING = 1'b1
    } isi_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_spike_prev;
    logic             r_arm;
    logic [WIN_W-1:0] r_win_len_q;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_spike_cnt;
    logic [CNT_W-1:0] r_rate_out;
    logic             r_rate_valid;
    isi_state_t       r_state;
    logic [CNT_W-1:0] r_isi_cnt;
    logic [CNT_W-1:0] r_isi_out;
    logic             r_isi_valid;
    logic             r_isi_sat;

    logic             w_edge_en;
    logic [WIN_W-1:0] w_len_cur;
    logic [WIN_W-1:0] w_len_m1;
    logic             w_last;
    logic [CNT_W-1:0] w_spike_nxt;
    isi_state_t       w_state_nxt;
    logic             w_isi_capture;
    logic             w_isi_restart;

    // Edges seen while ena is low are dropped, not deferred.
    assign w_edge_en = spike_in & ~r_spike_prev & ena;
    // r_arm marks the first cycle after reset/clear, when win_len has not been latched yet.
    assign w_len_cur = r_arm ? win_len : r_win_len_q;
    // A length of 0 wraps to all ones, giving a 2^WIN_W cycle window.
    assign w_len_m1  = w_len_cur - WIN_W'(1);
    assign w_last    = (r_win_cnt == w_len_m1);

    always_comb begin
        w_spike_nxt = r_spike_cnt;
        if (w_edge_en && (r_spike_cnt != CNT_MAX)) begin
            w_spike_nxt = r_spike_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_prev <= 1'b0;
            r_arm        <= 1'b1;
            r_win_len_q  <= '0;
            r_win_cnt    <= '0;
            r_spike_cnt  <= '0;
            r_rate_out   <= '0;
            r_rate_valid <= 1'b0;
        end else if (clear) begin
            r_spike_prev <= 1'b0;
            r_arm        <= 1'b1;
            r_win_len_q  <= '0;
            r_win_cnt    <= '0;
            r_spike_cnt  <= '0;
            r_rate_out   <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_spike_prev <= spike_in;
            r_arm        <= 1'b0;
            r_rate_valid <= 1'b0;
            if (r_arm) begin
                r_win_len_q <= win_len;
            end
            if (ena) begin
                if (w_last) begin
                    r_rate_out   <= w_spike_nxt;
                    r_rate_valid <= 1'b1;
                    r_spike_cnt  <= '0;
                    r_win_cnt    <= '0;
                    r_win_len_q  <= win_len;
                end else begin
                    r_spike_cnt <= w_spike_nxt;
                    r_win_cnt   <= r_win_cnt + WIN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NO_REF;
        end else if (clear) begin
            r_state <= NO_REF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_isi_capture = 1'b0;
        w_isi_restart = 1'b0;
        case (r_state)
            NO_REF: begin
                if (w_edge_en) begin
                    w_state_nxt   = TIMING;
                    w_isi_restart = 1'b1;
                end
            end
            TIMING: begin
                if (w_edge_en) begin
                    w_isi_capture = 1'b1;
                    w_isi_restart = 1'b1;
                end
            end
            default: w_state_nxt = NO_REF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isi_cnt   <= '0;
            r_isi_out   <= '0;
            r_isi_valid <= 1'b0;
            r_isi_sat   <= 1'b0;
        end else if (clear) begin
            r_isi_cnt   <= '0;
            r_isi_out   <= '0;
            r_isi_valid <= 1'b0;
            r_isi_sat   <= 1'b0;
        end else begin
            r_isi_valid <= 1'b0;
            if (w_isi_restart) begin
                r_isi_cnt <= CNT_W'(1);
            end else if (ena && (r_state == TIMING) && (r_isi_cnt != CNT_MAX)) begin
                r_isi_cnt <= r_isi_cnt + CNT_W'(1);
            end
            if (w_isi_capture) begin
                r_isi_out   <= r_isi_cnt;
                r_isi_sat   <= (r_isi_cnt == CNT_MAX);
                r_isi_valid <= 1'b1;
            end
        end
    end

    assign rate_out   = r_rate_out;
    assign rate_valid = r_rate_valid;
    assign isi_out    = r_isi_out;
    assign isi_valid  = r_isi_valid;
    assign isi_sat    = r_isi_sat;

endmodule
